// File: rtl/snax_reshuffler_pkg.sv
// Shared types and CSR register map for the multi-channel stream reshuffler.
// Imported by the lane, the top and the testbench.
package snax_reshuffler_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    MODE_PASS      = 1'b0,
    MODE_TRANSPOSE = 1'b1
  } mode_e;

  // Read-write CSR indices.
  localparam int unsigned CSR_MODE  = 0;
  localparam int unsigned CSR_COUNT = 1;
  localparam int unsigned CSR_MASK  = 2;

  // Read-only CSR indices.
  localparam int unsigned CSR_RO_BUSY = 0;
  localparam int unsigned CSR_RO_PERF = 1;

endpackage

// File: rtl/snax_reshuffler_mc_if.sv
// Valid/ready beat stream for one reshuffler channel.
// The master drives data and valid; the slave drives ready.
interface snax_reshuffler_mc_if #(
  parameter int unsigned DataWidth = 512
);

  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/snax_reshuffler_lane.sv
// One reshuffler channel: optional tile transpose on the way into a 2-entry
// FIFO, plus the input and output beat budgets for the current run.
module snax_reshuffler_lane
  import snax_reshuffler_pkg::*;
#(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned ElemWidth = 8,
  parameter int unsigned TileDim   = 8,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                start_en_i,
  input  logic [CntWidth-1:0] count_i,
  input  logic                active_i,
  input  mode_e               mode_i,
  output logic                done_o,
  snax_reshuffler_mc_if.slave  in_s,
  snax_reshuffler_mc_if.master out_s
);

  logic [DataWidth-1:0] beat_xpose;
  logic [DataWidth-1:0] beat_in;

  // Element (r,c) of the output tile is element (c,r) of the input tile.
  for (genvar r = 0; r < TileDim; r++) begin : g_row
    for (genvar c = 0; c < TileDim; c++) begin : g_col
      assign beat_xpose[(r*TileDim+c)*ElemWidth +: ElemWidth] =
        in_s.data[(c*TileDim+r)*ElemWidth +: ElemWidth];
    end
  end

  assign beat_in = (mode_i == MODE_TRANSPOSE) ? beat_xpose : in_s.data;

  logic [DataWidth-1:0] mem_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           cnt_q;
  logic [CntWidth-1:0]  in_rem_q;
  logic [CntWidth-1:0]  out_rem_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);

  assign in_s.ready  = active_i && (in_rem_q != '0) && !fifo_full;
  assign out_s.valid = !fifo_empty;
  assign out_s.data  = mem_q[rd_ptr_q];

  assign push = in_s.valid && in_s.ready;
  assign pop  = out_s.valid && out_s.ready;

  assign done_o = (out_rem_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_rem_q  <= '0;
      out_rem_q <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (start_i) begin
        in_rem_q  <= start_en_i ? count_i : '0;
        out_rem_q <= start_en_i ? count_i : '0;
      end else begin
        if (push) in_rem_q  <= in_rem_q - CntWidth'(1);
        if (pop)  out_rem_q <= out_rem_q - CntWidth'(1);
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by cnt_q, so
  // stale contents are never presented with valid asserted.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= beat_in;
  end

endmodule

// File: rtl/snax_reshuffler_mc.sv
// Multi-channel stream reshuffler: CSR-configured run of N beats per enabled
// channel, pass-through or tile transpose, with busy flag and cycle counter.
module snax_reshuffler_mc
  import snax_reshuffler_pkg::*;
#(
  parameter int unsigned NumCh        = 2,
  parameter int unsigned DataWidth    = 512,
  parameter int unsigned ElemWidth    = 8,
  parameter int unsigned TileDim      = 8,
  parameter int unsigned RegRWCount   = 3,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumCh-1:0][DataWidth-1:0]        stream2acc_data_i,
  input  logic [NumCh-1:0]                       stream2acc_valid_i,
  output logic [NumCh-1:0]                       stream2acc_ready_o,
  output logic [NumCh-1:0][DataWidth-1:0]        acc2stream_data_o,
  output logic [NumCh-1:0]                       acc2stream_valid_o,
  input  logic [NumCh-1:0]                       acc2stream_ready_i,
  input  logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_i,
  input  logic                                   csr_reg_set_valid_i,
  output logic                                   csr_reg_set_ready_o,
  output logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_o
);

  if (TileDim * TileDim * ElemWidth != DataWidth) begin : g_bad_tile
    $error("snax_reshuffler_mc: TileDim*TileDim*ElemWidth must equal DataWidth");
  end
  if (NumCh < 1 || NumCh > 8) begin : g_bad_numch
    $error("snax_reshuffler_mc: NumCh must be in 1..8");
  end

  localparam logic [0:0] StIdle = ST_IDLE;
  localparam logic [0:0] StRun  = ST_RUN;

  logic [0:0]              state_q;
  mode_e                   mode_q;
  logic [RegDataWidth-1:0] count_q;
  logic [NumCh-1:0]        mask_q;
  logic [RegDataWidth-1:0] perf_q;

  logic                    busy;
  logic                    accept;
  logic                    go;
  logic [NumCh-1:0]        mask_d;
  logic [RegDataWidth-1:0] count_d;
  logic [NumCh-1:0]        lane_done;
  logic                    all_done;

  assign busy    = (state_q == StRun);
  assign mask_d  = csr_reg_set_i[CSR_MASK][NumCh-1:0];
  assign count_d = csr_reg_set_i[CSR_COUNT];

  assign csr_reg_set_ready_o = (state_q == StIdle);
  assign accept   = csr_reg_set_valid_i && csr_reg_set_ready_o;
  assign go       = accept && (count_d != '0) && (mask_d != '0);
  assign all_done = &lane_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= MODE_PASS;
      count_q <= '0;
      mask_q  <= '0;
      perf_q  <= '0;
    end else begin
      if (accept) begin
        mode_q  <= mode_e'(csr_reg_set_i[CSR_MODE][0]);
        count_q <= count_d;
        mask_q  <= mask_d;
        perf_q  <= '0;
      end else if (busy && (perf_q != '1)) begin
        perf_q <= perf_q + RegDataWidth'(1);
      end
      case (state_q)
        StIdle:  if (go) state_q <= StRun;
        StRun:   if (all_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // bit unassigned, which would otherwise infer a latch.
  always_comb begin
    csr_reg_ro_set_o                 = '0;
    csr_reg_ro_set_o[CSR_RO_BUSY][0] = busy;
    csr_reg_ro_set_o[CSR_RO_PERF]    = perf_q;
  end

  // count_q is kept as the readable record of the accepted configuration.
  logic unused_cfg;
  assign unused_cfg = ^{csr_reg_set_i[CSR_MODE][RegDataWidth-1:1],
                        csr_reg_set_i[CSR_MASK][RegDataWidth-1:NumCh],
                        count_q};

  for (genvar c = 0; c < NumCh; c++) begin : g_lane
    snax_reshuffler_mc_if #(.DataWidth(DataWidth)) in_s  ();
    snax_reshuffler_mc_if #(.DataWidth(DataWidth)) out_s ();

    assign in_s.data             = stream2acc_data_i[c];
    assign in_s.valid            = stream2acc_valid_i[c];
    assign stream2acc_ready_o[c] = in_s.ready;

    assign acc2stream_data_o[c]  = out_s.data;
    assign acc2stream_valid_o[c] = out_s.valid;
    assign out_s.ready           = acc2stream_ready_i[c];

    snax_reshuffler_lane #(
      .DataWidth(DataWidth),
      .ElemWidth(ElemWidth),
      .TileDim  (TileDim),
      .CntWidth (RegDataWidth)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (go),
      .start_en_i(mask_d[c]),
      .count_i   (count_d),
      .active_i  (busy && mask_q[c]),
      .mode_i    (mode_q),
      .done_o    (lane_done[c]),
      .in_s      (in_s),
      .out_s     (out_s)
    );
  end

endmodule

// File: tb/tb_snax_reshuffler_mc.sv
// Directed bench for snax_reshuffler_mc: table of single-beat transform
// vectors plus hand-written multi-beat, back-pressure, CSR and reset sequences.
module tb_snax_reshuffler_mc;
  import snax_reshuffler_pkg::*;

  localparam int NumCh        = 2;
  localparam int DataWidth    = 512;
  localparam int ElemWidth    = 8;
  localparam int TileDim      = 8;
  localparam int RegRWCount   = 3;
  localparam int RegROCount   = 2;
  localparam int RegDataWidth = 32;
  localparam int MaxBeats     = 4;

  typedef logic [DataWidth-1:0] beat_t;
  typedef struct {
    mode_e mode;
    beat_t din;
    beat_t dout;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NumCh-1:0][DataWidth-1:0]         s2a_data;
  logic [NumCh-1:0]                        s2a_valid;
  logic [NumCh-1:0]                        s2a_ready;
  logic [NumCh-1:0][DataWidth-1:0]         a2s_data;
  logic [NumCh-1:0]                        a2s_valid;
  logic [NumCh-1:0]                        rdy_i;
  logic [RegRWCount-1:0][RegDataWidth-1:0] csr_set;
  logic                                    csr_valid;
  logic                                    csr_ready;
  logic [RegROCount-1:0][RegDataWidth-1:0] csr_ro;

  beat_t            drv_data [NumCh];
  logic [NumCh-1:0] drv_valid;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    snax_reshuffler_mc_if #(.DataWidth(DataWidth)) src_if ();
    assign src_if.data  = drv_data[c];
    assign src_if.valid = drv_valid[c];
    assign src_if.ready = s2a_ready[c];
    assign s2a_data[c]  = src_if.data;
    assign s2a_valid[c] = src_if.valid;
  end

  snax_reshuffler_mc #(
    .NumCh(NumCh), .DataWidth(DataWidth), .ElemWidth(ElemWidth), .TileDim(TileDim),
    .RegRWCount(RegRWCount), .RegROCount(RegROCount), .RegDataWidth(RegDataWidth)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .stream2acc_data_i  (s2a_data),
    .stream2acc_valid_i (s2a_valid),
    .stream2acc_ready_o (s2a_ready),
    .acc2stream_data_o  (a2s_data),
    .acc2stream_valid_o (a2s_valid),
    .acc2stream_ready_i (rdy_i),
    .csr_reg_set_i      (csr_set),
    .csr_reg_set_valid_i(csr_valid),
    .csr_reg_set_ready_o(csr_ready),
    .csr_reg_ro_set_o   (csr_ro)
  );

  int checks = 0;
  int failures = 0;

  beat_t            src   [NumCh][MaxBeats];
  beat_t            exp_b [NumCh][MaxBeats];
  beat_t            last_out [NumCh];
  int               in_idx  [NumCh];
  int               out_idx [NumCh];
  int               n_beats;
  logic [NumCh-1:0] mask_cur;

  task automatic check(input string name, input logic [DataWidth-1:0] act,
                       input logic [DataWidth-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic beat_t beat_of(input int c, input int k);
    beat_t b;
    for (int i = 0; i < DataWidth / 8; i++) b[i*8 +: 8] = 8'(i + 16 * k + 128 * c);
    return b;
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < NumCh; c++) begin
      drv_valid[c] = mask_cur[c] && (in_idx[c] < n_beats);
      drv_data[c]  = drv_valid[c] ? src[c][in_idx[c]] : '0;
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic configure(input logic mode, input int count, input logic [NumCh-1:0] mask);
    csr_set[CSR_MODE]  = {31'b0, mode};
    csr_set[CSR_COUNT] = count;
    csr_set[CSR_MASK]  = {30'b0, mask};
    csr_valid = 1'b1;
    @(posedge clk_i); #1;
    csr_valid = 1'b0;
    n_beats  = count;
    mask_cur = mask;
    for (int c = 0; c < NumCh; c++) begin
      in_idx[c]  = 0;
      out_idx[c] = 0;
    end
    drive_inputs();
  endtask

  task automatic step_cycles(input int n, input logic [NumCh-1:0] rdy);
    logic [NumCh-1:0] hs_in, hs_out;
    repeat (n) begin
      rdy_i = rdy;
      @(negedge clk_i);
      hs_in  = s2a_valid & s2a_ready;
      hs_out = a2s_valid & rdy_i;
      for (int c = 0; c < NumCh; c++) begin
        if (hs_out[c]) begin
          last_out[c] = a2s_data[c];
          if (out_idx[c] < MaxBeats)
            check($sformatf("data_ch%0d_beat%0d", c, out_idx[c]), a2s_data[c],
                  exp_b[c][out_idx[c]]);
          else
            check($sformatf("extra_beat_ch%0d", c), out_idx[c], n_beats);
        end
      end
      @(posedge clk_i); #1;
      for (int c = 0; c < NumCh; c++) begin
        if (hs_in[c])  in_idx[c]++;
        if (hs_out[c]) out_idx[c]++;
      end
      drive_inputs();
    end
  endtask

  task automatic run_until_idle(input int max_cycles, input logic [NumCh-1:0] rdy);
    int cyc = 0;
    while (csr_ro[CSR_RO_BUSY][0] && cyc < max_cycles) begin
      step_cycles(1, rdy);
      cyc++;
    end
    check("idle_within_budget", csr_ro[CSR_RO_BUSY][0], 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_o"}, s2a_ready, 0);
    check({tag, "_valid_o"}, a2s_valid, 0);
    check({tag, "_csr_ready"}, csr_ready, 1);
    check({tag, "_ro_busy"}, csr_ro[CSR_RO_BUSY], 0);
    check({tag, "_ro_perf"}, csr_ro[CSR_RO_PERF], 0);
  endtask

  vec_t  vecs [6];
  beat_t ident, ident_t, onehot, onehot_t;

  initial begin
    // Transform vectors; the transpose of byte i = i puts c*8+r at byte r*8+c.
    for (int i = 0; i < 64; i++) ident[i*8 +: 8] = 8'(i);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) ident_t[(r*8+c)*8 +: 8] = 8'(c * 8 + r);
    onehot   = '0; onehot[15:8]    = 8'hFF;
    onehot_t = '0; onehot_t[71:64] = 8'hFF;
    vecs[0] = '{MODE_PASS,      ident,               ident};
    vecs[1] = '{MODE_TRANSPOSE, ident,               ident_t};
    vecs[2] = '{MODE_TRANSPOSE, onehot,              onehot_t};
    vecs[3] = '{MODE_TRANSPOSE, {64{8'hAA}},         {64{8'hAA}}};
    vecs[4] = '{MODE_PASS,      {16{32'hDEADBEEF}},  {16{32'hDEADBEEF}}};
    vecs[5] = '{MODE_TRANSPOSE, ident_t,             ident};

    csr_set = '0; csr_valid = 1'b0; rdy_i = '0; drv_valid = '0;
    for (int c = 0; c < NumCh; c++) drv_data[c] = '0;
    n_beats = 0; mask_cur = '0;

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("in_reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("after_reset");

    // Four-beat pass-through run on both channels.
    for (int c = 0; c < NumCh; c++)
      for (int k = 0; k < MaxBeats; k++) begin
        src[c][k]   = beat_of(c, k);
        exp_b[c][k] = src[c][k];
      end
    configure(1'b0, 4, 2'b11);
    check("run_busy", csr_ro[CSR_RO_BUSY], 1);
    check("run_ready_o", s2a_ready, 2'b11);
    check("run_csr_ready", csr_ready, 0);
    step_cycles(1, 2'b11);
    check("latency_valid_o", a2s_valid, 2'b11);
    run_until_idle(30, 2'b11);
    for (int c = 0; c < NumCh; c++)
      check($sformatf("run4_out_count_ch%0d", c), out_idx[c], 4);
    check("run4_perf", csr_ro[CSR_RO_PERF], 6);
    step_cycles(3, 2'b11);
    check("run4_perf_hold", csr_ro[CSR_RO_PERF], 6);

    // Single-beat transform table.
    foreach (vecs[v]) begin
      for (int c = 0; c < NumCh; c++) begin
        src[c][0]   = vecs[v].din;
        exp_b[c][0] = vecs[v].dout;
      end
      configure(vecs[v].mode, 1, 2'b11);
      run_until_idle(20, 2'b11);
      for (int c = 0; c < NumCh; c++)
        check($sformatf("vec%0d_out_count_ch%0d", v, c), out_idx[c], 1);
      check($sformatf("vec%0d_perf", v), csr_ro[CSR_RO_PERF], 3);
      if (v == 1) begin
        check("xpose_byte1", last_out[0][15:8], 8);
        check("xpose_byte9", last_out[0][79:72], 9);
      end
    end

    // Empty mask: no-op, counter cleared.
    configure(1'b0, 4, 2'b00);
    step_cycles(2, 2'b11);
    check("mask0_busy", csr_ro[CSR_RO_BUSY], 0);
    check("mask0_perf", csr_ro[CSR_RO_PERF], 0);
    check("mask0_ready_o", s2a_ready, 0);

    // Back-pressure on channel 0 only.
    for (int c = 0; c < NumCh; c++)
      for (int k = 0; k < MaxBeats; k++) begin
        src[c][k]   = beat_of(c, k);
        exp_b[c][k] = src[c][k];
      end
    configure(1'b0, 4, 2'b11);
    step_cycles(10, 2'b10);
    check("stall_ch0_accepted", in_idx[0], 2);
    check("stall_ch0_ready_o", s2a_ready[0], 0);
    check("stall_ch0_out", out_idx[0], 0);
    check("stall_ch1_out", out_idx[1], 4);
    check("stall_busy", csr_ro[CSR_RO_BUSY], 1);
    run_until_idle(30, 2'b11);
    check("stall_ch0_out_final", out_idx[0], 4);
    check("stall_ch1_out_final", out_idx[1], 4);

    // Zero count: no-op, counter cleared.
    configure(1'b0, 0, 2'b11);
    step_cycles(2, 2'b11);
    check("count0_busy", csr_ro[CSR_RO_BUSY], 0);
    check("count0_perf", csr_ro[CSR_RO_PERF], 0);
    check("count0_csr_ready", csr_ready, 1);

    // Config write during a run is ignored.
    configure(1'b0, 4, 2'b11);
    step_cycles(2, 2'b00);
    check("midrun_csr_ready", csr_ready, 0);
    csr_set[CSR_MODE]  = 32'd1;
    csr_set[CSR_COUNT] = 32'd1;
    csr_set[CSR_MASK]  = 32'd1;
    csr_valid = 1'b1;
    step_cycles(1, 2'b00);
    csr_valid = 1'b0;
    check("midrun_still_busy", csr_ro[CSR_RO_BUSY], 1);
    run_until_idle(30, 2'b11);
    check("midrun_ch0_out", out_idx[0], 4);
    check("midrun_ch1_out", out_idx[1], 4);

    // Reset pulse mid-run, then a clean run.
    configure(1'b0, 4, 2'b11);
    step_cycles(3, 2'b11);
    rst_ni = 1'b0;
    #2;
    check_reset_outputs("midrun_reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    configure(1'b0, 2, 2'b11);
    run_until_idle(30, 2'b11);
    check("post_reset_ch0_out", out_idx[0], 2);
    check("post_reset_ch1_out", out_idx[1], 2);
    check("post_reset_perf", csr_ro[CSR_RO_PERF], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snax_reshuffler_mc.md
SNAX_RESHUFFLER_MC -- requirements
Module: snax_reshuffler_mc

Interface
REQ-001 SHALL have parameter NumCh, default 2: number of independent stream channels (1..8).
REQ-002 SHALL have parameter DataWidth, default 512: bits per channel beat.
REQ-003 SHALL have parameter ElemWidth, default 8: element width; TileDim*TileDim*ElemWidth SHALL equal DataWidth (elaboration error otherwise).
REQ-004 SHALL have parameter TileDim, default 8: side of the square element tile held in one beat.
REQ-005 SHALL have parameters RegRWCount=3, RegROCount=2, RegDataWidth=32: CSR register counts and width.
REQ-006 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports stream2acc_data_i/valid_i/ready_o, in/in/out, [NumCh][DataWidth]/[NumCh]/[NumCh]: per-channel input streams.
REQ-009 SHALL have ports acc2stream_data_o/valid_o/ready_i, out/out/in, [NumCh][DataWidth]/[NumCh]/[NumCh]: per-channel output streams.
REQ-010 SHALL have ports csr_reg_set_i, csr_reg_set_valid_i, csr_reg_set_ready_o, in/in/out, [RegRWCount][RegDataWidth]/1/1: config; reg0 bit0 = mode (0 pass, 1 transpose), reg1 = beats per channel, reg2[NumCh-1:0] = channel enable mask.
REQ-011 SHALL have port csr_reg_ro_set_o, out, [RegROCount][RegDataWidth]: reg0 bit0 = busy, bits[31:1] = 0; reg1 = performance counter.

Function
REQ-012 SHALL implement FSM IDLE, RUN; csr_reg_set_ready_o = 1 only in IDLE.
REQ-013 SHALL latch mode, count, mask on csr_reg_set_valid_i && csr_reg_set_ready_o; same cycle clear performance counter.
REQ-014 SHALL go IDLE->RUN on config accept when count != 0 and mask != 0; otherwise stay IDLE (no-op, counter still cleared).
REQ-015 SHALL load per enabled channel an input-remaining and an output-remaining counter with count; disabled channels hold ready_o=0, valid_o=0.
REQ-016 SHALL give each channel a 2-entry FIFO; stream2acc_ready_o[c] = RUN && enabled && in_rem[c]!=0 && FIFO not full.
REQ-017 SHALL, on input handshake, write the transformed beat into the FIFO and decrement in_rem[c]; output data taken from FIFO head, valid_o[c] = FIFO not empty.
REQ-018 SHALL in mode 0 pass beats unchanged; in mode 1 output element (r,c) = input element (c,r), element i = r*TileDim+c at bits [i*ElemWidth +: ElemWidth].
REQ-019 SHALL give latency 1 cycle input-handshake to valid_o (empty FIFO) and sustain 1 beat/cycle/channel when ready_i held high.
REQ-020 SHALL allow simultaneous FIFO push and pop when full (pop frees slot same cycle is NOT required; full means ready_o=0).
REQ-021 SHALL decrement out_rem[c] on output handshake; channel done when out_rem[c]==0.
REQ-022 SHALL go RUN->IDLE the cycle after all enabled channels are done; busy = (state==RUN).
REQ-023 SHALL increment performance counter each RUN cycle, saturating at 2^32-1, holding value in IDLE.
REQ-024 SHALL treat channels independently: back-pressure on one channel SHALL NOT stall others.
REQ-025 SHALL ignore csr_reg_set_valid_i while busy (no config change mid-run).

Reset
REQ-026 SHALL on rst_ni low asynchronously set state IDLE, FIFOs empty, counters 0, latched config 0.
REQ-027 SHALL after reset drive valid_o=0, ready_o=0, csr_reg_set_ready_o=1, csr_reg_ro_set_o all 0; reset mid-run discards in-flight beats.

Structure
REQ-028 SHALL place state enum, mode enum and CSR register index constants in package snax_reshuffler_pkg.
REQ-029 SHALL instantiate per channel sub-module snax_reshuffler_lane (FIFO, counters, transpose mux); top holds FSM, CSR latch, perf counter.

Verification
REQ-030 Mode 0, NumCh=2, count=4, mask=3, ready_i=1 -> 4 identical beats per channel, busy falls after last output, perf counter = 5-6 cycles documented value.
REQ-031 Mode 1, input byte i = i -> output byte r*8+c = c*8+r (e.g. byte 1 = 8, byte 9 = 9).
REQ-032 ready_i[0]=0 for 10 cycles, ch1 free-running -> ch0 accepts exactly 2 beats then ready_o[0]=0; ch1 completes unaffected.
REQ-033 count=0 or mask=0 -> stays IDLE, busy=0, perf counter=0.
REQ-034 CSR valid during RUN -> ignored, config unchanged; rst_ni pulse mid-run -> all outputs reset values, next config runs clean.
